// File: rtl/tri_param_nw_ary.sv
// rtl/tri_param_nw_ary.sv - multi-way synchronous array with post-reset zero sweep
// One single-port RAM per way; INIT clears every entry, RUN serves write-first reads.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 1
`endif

module tri_param_nw_ary #(
  parameter int WAYS   = 4,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int WIDTH  = 168
) (
  input  logic [0:`NCLK_WIDTH-1]  nclk,
  input  logic                    reset_b,
  input  logic                    act,
  input  logic [0:ADDR_W-1]       addr,
  input  logic [0:WAYS-1]         way_we,
  input  logic [0:WIDTH-1]        data_in,
  output logic [0:WAYS*WIDTH-1]   data_out,
  output logic                    init_done,
  input  logic                    abst_scan_in,
  output logic                    abst_scan_out
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic clk;
  logic unused_nclk;
  assign clk         = nclk[0];
  assign unused_nclk = ^nclk;

  assign abst_scan_out = abst_scan_in;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_l;
  logic [WIDTH-1:0]    din_l;
  logic                in_range;
  logic                wr_ok;
  logic [ADDR_W-1:0]   ram_addr;
  logic [WIDTH-1:0]    ram_wdata;

  assign addr_l = addr;
  assign din_l  = data_in;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  // The sweep owns the RAM port during INIT; nothing is written while reset is low.
  always_comb begin
    init_done = (state_q == RUN);
    in_range  = ({1'b0, addr_l} < DEPTH_X);
    if (state_q == INIT) begin
      ram_addr  = cnt_q;
      ram_wdata = '0;
    end else begin
      ram_addr  = addr_l;
      ram_wdata = din_l;
    end
    wr_ok = reset_b & ((state_q == INIT) | (act & in_range));
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             we;

    assign we = wr_ok & ((state_q == INIT) | way_we[w]);

    always_ff @(posedge clk) begin
      if (we) begin
        mem[ram_addr] <= ram_wdata;
      end
    end

    always_comb begin
      rd_d = rd_q;
      if (state_q == INIT) begin
        rd_d = '0;
      end else if (act) begin
        if (!in_range) begin
          rd_d = '0;
        end else if (way_we[w]) begin
          rd_d = din_l;
        end else begin
          rd_d = mem[ram_addr];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_b) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign data_out[w*WIDTH +: WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_tri_param_nw_ary.sv
// tb/tb_tri_param_nw_ary.sv - directed bench for tri_param_nw_ary (default and small configs)
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 1
`endif

module tb_tri_param_nw_ary;

  localparam int AW = 4, AD = 128, AA = 7, AWD = 168;
  localparam int BW = 1, BD = 100, BA = 7, BWD = 36;

  logic [0:`NCLK_WIDTH-1] nclk = '0;
  always #5 nclk[0] = ~nclk[0];

  logic              a_rst = 1'b0, a_act = 1'b0, a_si = 1'b0, a_so, a_done;
  logic [0:AA-1]     a_addr = '0;
  logic [0:AW-1]     a_we = '0;
  logic [0:AWD-1]    a_din = '0;
  logic [0:AW*AWD-1] a_dout;

  logic              b_rst = 1'b0, b_act = 1'b0, b_si = 1'b0, b_so, b_done;
  logic [0:BA-1]     b_addr = '0;
  logic [0:BW-1]     b_we = '0;
  logic [0:BWD-1]    b_din = '0;
  logic [0:BW*BWD-1] b_dout;

  int checks = 0;
  int errors = 0;

  tri_param_nw_ary #(.WAYS(AW), .DEPTH(AD), .ADDR_W(AA), .WIDTH(AWD)) u_a (
    .nclk(nclk), .reset_b(a_rst), .act(a_act), .addr(a_addr), .way_we(a_we),
    .data_in(a_din), .data_out(a_dout), .init_done(a_done),
    .abst_scan_in(a_si), .abst_scan_out(a_so)
  );

  tri_param_nw_ary #(.WAYS(BW), .DEPTH(BD), .ADDR_W(BA), .WIDTH(BWD)) u_b (
    .nclk(nclk), .reset_b(b_rst), .act(b_act), .addr(b_addr), .way_we(b_we),
    .data_in(b_din), .data_out(b_dout), .init_done(b_done),
    .abst_scan_in(b_si), .abst_scan_out(b_so)
  );

  task automatic step();
    @(posedge nclk[0]);
    #1;
  endtask

  function automatic logic [0:AWD-1] pat(input logic [7:0] b);
    return {21{b}};
  endfunction

  function automatic logic [0:AW*AWD-1] pack4(input logic [0:AWD-1] w0, w1, w2, w3);
    return {w0, w1, w2, w3};
  endfunction

  task automatic test_reset();
    a_rst = 1'b0; a_act = 1'b1; a_we = '1; a_din = pat(8'h77);
    step(); step();
    checks++;
    if (a_dout !== '0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state dout=%h done=%b exp 0/0", a_dout, a_done);
    end
    a_rst = 1'b1;
    for (int k = 1; k <= AD; k++) begin
      a_we   = 4'($urandom);
      a_addr = 7'($urandom);
      step();
      checks++;
      if (a_done !== (k >= AD)) begin
        errors++;
        $display("FAIL init_done_k%0d got %b exp %b", k, a_done, (k >= AD));
      end
      checks++;
      if (a_dout !== '0) begin
        errors++;
        $display("FAIL init_dout_k%0d got %h exp 0", k, a_dout);
      end
    end
    a_we = '0;
    for (int a = 0; a < AD; a++) begin
      a_addr = 7'(a);
      step();
      checks++;
      if (a_dout !== '0) begin
        errors++;
        $display("FAIL cleared_addr%0d got %h exp 0", a, a_dout);
      end
    end
  endtask

  task automatic test_write_way2();
    logic [0:AW*AWD-1] exp;
    exp = pack4('0, '0, pat(8'hA5), '0);
    a_act = 1'b1; a_addr = 7'd5; a_we = '0; a_we[2] = 1'b1; a_din = pat(8'hA5);
    step();
    checks++;
    if (a_dout !== exp) begin
      errors++;
      $display("FAIL way2_write got %h exp %h", a_dout, exp);
    end
    a_we = '0; a_addr = 7'd6;
    step();
    checks++;
    if (a_dout !== '0) begin
      errors++;
      $display("FAIL way2_neighbor got %h exp 0", a_dout);
    end
    a_addr = 7'd5;
    step();
    checks++;
    if (a_dout !== exp) begin
      errors++;
      $display("FAIL way2_readback got %h exp %h", a_dout, exp);
    end
  endtask

  task automatic test_write_first();
    logic [0:AW*AWD-1] exp;
    a_act = 1'b1; a_addr = 7'd9;
    for (int w = 0; w < AW; w++) begin
      a_we = '0; a_we[w] = 1'b1; a_din = pat(8'(8'h10 + w));
      step();
    end
    exp = pack4(pat(8'hC3), pat(8'h11), pat(8'h12), pat(8'h13));
    a_we = '0; a_we[0] = 1'b1; a_din = pat(8'hC3);
    step();
    checks++;
    if (a_dout !== exp) begin
      errors++;
      $display("FAIL write_first got %h exp %h", a_dout, exp);
    end
    a_we = '0; a_din = '0;
    step();
    checks++;
    if (a_dout !== exp) begin
      errors++;
      $display("FAIL write_first_reread got %h exp %h", a_dout, exp);
    end
  endtask

  task automatic test_act_hold();
    logic [0:AW*AWD-1] exp;
    exp = {AW{pat(8'h5A)}};
    a_act = 1'b1; a_addr = 7'd3; a_we = '1; a_din = pat(8'h5A);
    step();
    a_we = '0;
    step();
    checks++;
    if (a_dout !== exp) begin
      errors++;
      $display("FAIL act_read3 got %h exp %h", a_dout, exp);
    end
    a_act = 1'b0; a_we = '1; a_din = pat(8'hFF);
    for (int i = 0; i < 5; i++) begin
      a_addr = 7'(i * 7 + 1);
      step();
      checks++;
      if (a_dout !== exp) begin
        errors++;
        $display("FAIL act0_hold_c%0d got %h exp %h", i, a_dout, exp);
      end
    end
    a_act = 1'b1; a_we = '0; a_addr = 7'd3;
    step();
    checks++;
    if (a_dout !== exp) begin
      errors++;
      $display("FAIL act0_addr3 got %h exp %h", a_dout, exp);
    end
    a_addr = 7'd1;
    step();
    checks++;
    if (a_dout !== '0) begin
      errors++;
      $display("FAIL act0_nowrite got %h exp 0", a_dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:AW*AWD-1] exp;
    a_act = 1'b1; a_we = '1;
    for (int i = 0; i < 4; i++) begin
      a_addr = 7'(20 + i); a_din = pat(8'(8'h30 + i));
      exp = {AW{pat(8'(8'h30 + i))}};
      step();
      checks++;
      if (a_dout !== exp) begin
        errors++;
        $display("FAIL b2b_write%0d got %h exp %h", i, a_dout, exp);
      end
    end
    a_we = '0;
    for (int i = 0; i < 4; i++) begin
      a_addr = 7'(20 + i);
      exp = {AW{pat(8'(8'h30 + i))}};
      step();
      checks++;
      if (a_dout !== exp) begin
        errors++;
        $display("FAIL b2b_read%0d got %h exp %h", i, a_dout, exp);
      end
    end
  endtask

  task automatic test_scan();
    for (int v = 0; v < 2; v++) begin
      a_si = v[0]; b_si = ~v[0];
      #1;
      checks++;
      if (a_so !== v[0] || b_so !== ~v[0]) begin
        errors++;
        $display("FAIL scan_pass%0d got %b%b exp %b%b", v, a_so, b_so, v[0], ~v[0]);
      end
    end
  endtask

  task automatic test_reset_restart();
    a_rst = 1'b0; a_act = 1'b1; a_we = '1; a_addr = 7'd5; a_din = pat(8'hEE);
    step();
    checks++;
    if (a_dout !== '0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_run dout=%h done=%b exp 0/0", a_dout, a_done);
    end
    a_rst = 1'b1;
    for (int k = 0; k < 60; k++) step();
    a_rst = 1'b0;
    step();
    a_rst = 1'b1;
    for (int k = 1; k <= AD; k++) begin
      step();
      if (k >= AD - 1) begin
        checks++;
        if (a_done !== (k >= AD)) begin
          errors++;
          $display("FAIL rst_midinit_k%0d got %b exp %b", k, a_done, (k >= AD));
        end
      end
    end
    a_we = '0;
    for (int i = 0; i < 4; i++) begin
      a_addr = (i == 0) ? 7'd5 : (i == 1) ? 7'd9 : (i == 2) ? 7'd3 : 7'd21;
      step();
      checks++;
      if (a_dout !== '0) begin
        errors++;
        $display("FAIL rst_cleared%0d got %h exp 0", i, a_dout);
      end
    end
  endtask

  task automatic test_small();
    b_rst = 1'b0; b_act = 1'b1; b_we = 1'b1; b_din = 36'h0F0F0F0F0;
    step(); step();
    b_rst = 1'b1;
    for (int k = 1; k <= BD; k++) begin
      step();
      if (k >= BD - 1) begin
        checks++;
        if (b_done !== (k >= BD)) begin
          errors++;
          $display("FAIL small_init_k%0d got %b exp %b", k, b_done, (k >= BD));
        end
      end
    end
    b_addr = 7'd120; b_din = 36'h123456789;
    step();
    checks++;
    if (b_dout !== '0) begin
      errors++;
      $display("FAIL small_oor_write got %h exp 0", b_dout);
    end
    b_addr = 7'd99; b_din = 36'hABCDE0123;
    step();
    checks++;
    if (b_dout !== 36'hABCDE0123) begin
      errors++;
      $display("FAIL small_last_write got %h exp abcde0123", b_dout);
    end
    b_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_addr = (i == 0) ? 7'd120 : (i == 1) ? 7'd20 : 7'd99;
      step();
      checks++;
      if (b_dout !== ((i == 2) ? 36'hABCDE0123 : 36'h0)) begin
        errors++;
        $display("FAIL small_read%0d got %h exp %h", i, b_dout, (i == 2) ? 36'hABCDE0123 : 36'h0);
      end
    end
    b_we = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b_addr = 7'(i); b_din = 36'(i + 1);
      step();
    end
    b_we = 1'b0; b_addr = 7'd10;
    step();
    checks++;
    if (b_dout !== 36'd11) begin
      errors++;
      $display("FAIL small_run_write got %h exp b", b_dout);
    end
    b_rst = 1'b0;
    step();
    b_rst = 1'b1;
    for (int k = 1; k <= BD; k++) begin
      step();
      checks++;
      if (b_done !== (k >= BD)) begin
        errors++;
        $display("FAIL small_reinit_k%0d got %b exp %b", k, b_done, (k >= BD));
      end
    end
    for (int i = 0; i < 4; i++) begin
      b_addr = (i == 0) ? 7'd0 : (i == 1) ? 7'd10 : (i == 2) ? 7'd39 : 7'd99;
      step();
      checks++;
      if (b_dout !== '0) begin
        errors++;
        $display("FAIL small_cleared%0d got %h exp 0", i, b_dout);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_way2();
    test_write_first();
    test_act_hold();
    test_back_to_back();
    test_scan();
    test_reset_restart();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
